conv_window_buffer: RTL and testbench
=====================================

Name: conv_window_buffer

Overview:
- Streaming sliding-window generator for the convolution datapath.
- Accepts raster-ordered pixels, which may be multi-channel, over a valid/ready handshake. Outputs a registered WIN_H x WIN_W window.
- Asserts window_valid only when the full window lies inside the image, so windows never wrap across rows or frames.
- Sits between the input pixel stream and the parallel multiply-accumulate array. Supersedes the fixed-size dense shift register: adds image-width awareness, channels, backpressure and frame tracking.

Parameters:
- DATA_W, 8, bits per channel sample.
- CHANNELS, 1, parallel channels per pixel.
- WIN_W, 3, window columns (≥1).
- WIN_H, 3, window rows (≥1).
- IMG_W, 4, image width in pixels (≥ WIN_W).
- IMG_H, 4, image height in pixels (≥ WIN_H).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sof  in  1  start of frame; qualified by an accepted transfer.
- in_data  in  DATA_W*CHANNELS  pixel; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  1  pixel present.
- in_ready  out  1  buffer can accept a pixel.
- window_out  out  DATA_W*CHANNELS*WIN_W*WIN_H  window contents.
- window_valid  out  1  window_out holds a complete in-image window.
- out_ready  in  1  consumer takes the window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (asynchronous, reset=0):
  - All shift-register stages, column/row counters, window_valid and frame_done clear to 0.
  - Reset mid-frame discards all partial state. The next accepted pixel is (row 0, col 0).
- Handshake:
  - in_ready = !(window_valid && !out_ready). This is combinational, with no in_valid→in_ready path.
  - accept = in_valid && in_ready.
- Storage:
  - Flat shift register of L = (WIN_H-1)*IMG_W + WIN_W pixels; shifts by one pixel only on accept.
  - On a stall the contents hold unchanged.
- Window mapping, for element (r, c) with r, c = 0 the newest:
  - It equals the pixel accepted r*IMG_W + c accepts ago.
  - It occupies window_out bits [((r*WIN_W + c)*CHANNELS)*DATA_W +: DATA_W*CHANNELS].
  - Row 0 therefore occupies the least-significant bits, and the newest pixel sits at bit 0.
- Position counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the pixel being accepted.
  - On accept: col increments. At IMG_W-1 it wraps to 0 and row increments. At (IMG_H-1, IMG_W-1) both wrap to 0.
  - If sof=1 on accept, the pixel is treated as (0,0) regardless of the counters, and the counters advance from there. Shift contents are not cleared; validity gating covers stale data.
- window_valid (registered; latency of one clock after the accepting edge):
  - On accept: next = (row ≥ WIN_H-1) && (col ≥ WIN_W-1), evaluated on the accepted pixel's position.
  - No accept and out_ready=1: next = 0.
  - No accept and out_ready=0: holds. window_out is stable while window_valid=1 and out_ready=0.
  - Accept and consume in the same cycle is legal: the window is replaced the next cycle, giving full throughput.
- frame_done: registered pulse, 1 for exactly one cycle after accepting pixel (IMG_H-1, IMG_W-1).
- Windows per frame = (IMG_H-WIN_H+1)*(IMG_W-WIN_W+1).
- in_valid=0 idle cycles do not alter the contents.

Test Plan (defaults, CHANNELS=1; window rows written {c2,c1,c0} MSB→LSB, row 0 = bits [23:0]):
- Reset, then stream pixels 0..15 with in_valid=1, sof=1 on pixel 0, out_ready=1:
  - window_valid is first 1 the cycle after pixel 10 is accepted.
  - Row 0 = {8,9,10}, row 1 = {4,5,6}, row 2 = {0,1,2}.
- Same stream, next window (after pixel 11):
  - Row 0 = {9,10,11}, row 1 = {5,6,7}, row 2 = {1,2,3}.
  - window_valid = 0 after pixels 12 and 13.
  - After pixel 14: row 0 = {12,13,14}, row 1 = {8,9,10}, row 2 = {4,5,6}.
  - After pixel 15: valid, and frame_done = 1 for one cycle.
  - Exactly 4 valid windows in total.
- Backpressure:
  - Hold out_ready=0 when the first window appears: in_ready=0, window_out stays {8,9,10}/{4,5,6}/{0,1,2} for 5 cycles.
  - Release: the next accepted pixel 11 yields the {9,10,11} window. No pixel is lost or duplicated.
- Bubbles: insert in_valid=0 gaps between random pixels of the 0..15 stream → windows identical to the continuous case.
- Mid-frame sof: after pixels 0..6, send 100..115 with sof on 100 → the first valid window follows 110, with row 0 = {108,109,110} and row 2 = {100,101,102}.
- Reset mid-frame (after pixel 9):
  - All outputs are 0 immediately.
  - The stream 0..15 afterwards reproduces the scenario 1 results.

Source files
------------

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for conv_window_buffer.
// The buffer takes the slave side; the pixel source and window consumer form the master side.
interface conv_window_buffer_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned WIN_W    = 3,
  parameter int unsigned WIN_H    = 3
);
  localparam int unsigned PIX_W = DATA_W * CHANNELS;

  logic                           sof;
  logic [PIX_W-1:0]               in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [PIX_W*WIN_W*WIN_H-1:0]   window_out;
  logic                           window_valid;
  logic                           out_ready;
  logic                           frame_done;

  modport master (
    output sof, in_data, in_valid, out_ready,
    input  in_ready, window_out, window_valid, frame_done
  );

  modport slave (
    input  sof, in_data, in_valid, out_ready,
    output in_ready, window_out, window_valid, frame_done
  );
endinterface

// File: rtl/conv_window_buffer.sv
// Streaming WIN_H x WIN_W sliding-window generator over a raster pixel stream.
// Windows are flagged valid only when fully inside the image (no row/frame wrap).
module conv_window_buffer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned WIN_W    = 3,
  parameter int unsigned WIN_H    = 3,
  parameter int unsigned IMG_W    = 4,
  parameter int unsigned IMG_H    = 4
) (
  input logic                  clock,
  input logic                  reset,
  conv_window_buffer_if.slave  bus
);
  localparam int unsigned PIX_W = DATA_W * CHANNELS;
  localparam int unsigned DEPTH = (WIN_H - 1) * IMG_W + WIN_W;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN_W - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN_H - 1);

  logic [DEPTH-1:0][PIX_W-1:0]  r_shift;
  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic                         r_window_valid;
  logic                         r_frame_done;

  logic [COL_W-1:0]             w_col;
  logic [ROW_W-1:0]             w_row;
  logic                         w_in_ready;
  logic                         w_accept;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_win_ok;
  logic [PIX_W*WIN_W*WIN_H-1:0] w_window;

  assign w_in_ready = !(r_window_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // sof forces the accepted pixel to (0,0); stale shift contents are masked by w_win_ok
  assign w_col      = bus.sof ? '0 : r_col;
  assign w_row      = bus.sof ? '0 : r_row;
  assign w_col_last = (w_col == COL_LAST);
  assign w_row_last = (w_row == ROW_LAST);
  assign w_win_ok   = (w_row >= ROW_MIN) && (w_col >= COL_MIN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift        <= '0;
      r_col          <= '0;
      r_row          <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_row_last && w_col_last;
      if (w_accept) begin
        r_shift[0] <= bus.in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          r_shift[i] <= r_shift[i-1];
        end
        r_col          <= w_col_last ? '0 : w_col + 1'b1;
        r_row          <= w_col_last ? (w_row_last ? '0 : w_row + 1'b1) : w_row;
        r_window_valid <= w_win_ok;
      end else if (bus.out_ready) begin
        r_window_valid <= 1'b0;
      end
    end
  end

  // Element (r,c) is the pixel accepted r*IMG_W + c transfers ago; row 0 / newest at LSB
  always_comb begin
    w_window = '0;
    for (int unsigned r = 0; r < WIN_H; r++) begin
      for (int unsigned c = 0; c < WIN_W; c++) begin
        w_window[(r*WIN_W + c)*PIX_W +: PIX_W] = r_shift[r*IMG_W + c];
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.window_out   = w_window;
  assign bus.window_valid = r_window_valid;
  assign bus.frame_done   = r_frame_done;
endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer with the default 3x3 window over a 4x4 image.
module tb_conv_window_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  conv_window_buffer_if #(.DATA_W(8), .CHANNELS(1), .WIN_W(3), .WIN_H(3)) bus ();

  conv_window_buffer #(
    .DATA_W(8), .CHANNELS(1), .WIN_W(3), .WIN_H(3), .IMG_W(4), .IMG_H(4)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_win    = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] win(input logic [23:0] r2, input logic [23:0] r1,
                                      input logic [23:0] r0);
    return {r2, r1, r0};
  endfunction

  task automatic do_reset;
    bus.in_valid  = 1'b0;
    bus.sof       = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic [7:0] v, input logic s);
    int unsigned waited = 0;
    bus.in_data  = v;
    bus.sof      = s;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (!bus.in_ready) check("accept_timeout", 72'd0, 72'd1);
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    if (bus.window_valid) n_win++;
  endtask

  task automatic stream_frame(input bit gaps);
    n_win = 0;
    for (int k = 0; k < 16; k++) begin
      send(8'(k), k == 0);
      check($sformatf("valid_px%0d", k), 72'(bus.window_valid),
            72'(k == 10 || k == 11 || k == 14 || k == 15));
      check($sformatf("fdone_px%0d", k), 72'(bus.frame_done), 72'(k == 15));
      if (k == 10) check("win_px10", bus.window_out,
                         win({8'd0, 8'd1, 8'd2}, {8'd4, 8'd5, 8'd6}, {8'd8, 8'd9, 8'd10}));
      if (k == 11) check("win_px11", bus.window_out,
                         win({8'd1, 8'd2, 8'd3}, {8'd5, 8'd6, 8'd7}, {8'd9, 8'd10, 8'd11}));
      if (k == 14) check("win_px14", bus.window_out,
                         win({8'd4, 8'd5, 8'd6}, {8'd8, 8'd9, 8'd10}, {8'd12, 8'd13, 8'd14}));
      if (k == 15) check("win_px15", bus.window_out,
                         win({8'd5, 8'd6, 8'd7}, {8'd9, 8'd10, 8'd11}, {8'd13, 8'd14, 8'd15}));
      if (gaps && (k % 3 == 1)) begin
        repeat (2) @(negedge clock);
        check("bubble_valid", 72'(bus.window_valid), 72'd0);
        if (k == 10) check("bubble_hold", bus.window_out,
                           win({8'd0, 8'd1, 8'd2}, {8'd4, 8'd5, 8'd6}, {8'd8, 8'd9, 8'd10}));
      end
    end
    @(negedge clock);
    check("fdone_pulse_end", 72'(bus.frame_done), 72'd0);
    check("valid_drop_idle", 72'(bus.window_valid), 72'd0);
    check("window_count", 72'(n_win), 72'd4);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sof       = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_valid", 72'(bus.window_valid), 72'd0);
    check("rst_fdone", 72'(bus.frame_done), 72'd0);
    check("rst_window", bus.window_out, 72'd0);
    check("rst_in_ready", 72'(bus.in_ready), 72'd1);

    // continuous stream
    do_reset();
    stream_frame(1'b0);

    // backpressure on the first window
    do_reset();
    n_win = 0;
    for (int k = 0; k < 10; k++) send(8'(k), k == 0);
    bus.out_ready = 1'b0;
    send(8'd10, 1'b0);
    bus.in_data  = 8'd11;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 72'(bus.in_ready), 72'd0);
      check("bp_valid", 72'(bus.window_valid), 72'd1);
      check("bp_window", bus.window_out,
            win({8'd0, 8'd1, 8'd2}, {8'd4, 8'd5, 8'd6}, {8'd8, 8'd9, 8'd10}));
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    send(8'd11, 1'b0);
    check("bp_win_px11", bus.window_out,
          win({8'd1, 8'd2, 8'd3}, {8'd5, 8'd6, 8'd7}, {8'd9, 8'd10, 8'd11}));
    for (int k = 12; k < 16; k++) begin
      send(8'(k), 1'b0);
      if (k == 14) check("bp_win_px14", bus.window_out,
                         win({8'd4, 8'd5, 8'd6}, {8'd8, 8'd9, 8'd10}, {8'd12, 8'd13, 8'd14}));
      if (k == 15) check("bp_fdone", 72'(bus.frame_done), 72'd1);
    end
    check("bp_window_count", 72'(n_win), 72'd4);

    // idle bubbles in the stream
    do_reset();
    stream_frame(1'b1);

    // sof arriving mid-frame
    do_reset();
    for (int k = 0; k < 7; k++) send(8'(k), k == 0);
    for (int k = 0; k < 16; k++) begin
      send(8'(100 + k), k == 0);
      if (k == 9)  check("sof_valid_px109", 72'(bus.window_valid), 72'd0);
      if (k == 10) begin
        check("sof_valid_px110", 72'(bus.window_valid), 72'd1);
        check("sof_win_px110", bus.window_out,
              win({8'd100, 8'd101, 8'd102}, {8'd104, 8'd105, 8'd106},
                  {8'd108, 8'd109, 8'd110}));
      end
      if (k == 15) check("sof_fdone", 72'(bus.frame_done), 72'd1);
    end

    // reset in the middle of a frame
    do_reset();
    for (int k = 0; k < 10; k++) send(8'(k), k == 0);
    reset = 1'b0;
    #1;
    check("midrst_window", bus.window_out, 72'd0);
    check("midrst_valid", 72'(bus.window_valid), 72'd0);
    check("midrst_fdone", 72'(bus.frame_done), 72'd0);
    @(negedge clock);
    reset = 1'b1;
    stream_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
